// File: rtl/mux4_rr_pkg.sv
// Shared definitions for the 4:1 round-robin mux and its 1:4 demux partner.
// The channel-index type fixes the sel encoding used at both ends of the path.
package mux4_rr_pkg;

   localparam int SEL_W  = 2;
   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;

   typedef logic [SEL_W-1:0] ch_idx_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: the first requester at or after ptr
// (mod 4) wins. The pointer itself is owned by the caller.
module rr_arbiter4
   import mux4_rr_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  ch_idx_t           ptr,
   output logic [NUM_CH-1:0] gnt,
   output ch_idx_t           gnt_idx,
   output logic              any
);

   ch_idx_t           w_cand [NUM_CH];
   logic [NUM_CH-1:0] w_hit;

   // w_cand[k] is the channel examined k-th in the rotated search order
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
      assign w_cand[gi] = ptr + ch_idx_t'(gi);
      assign w_hit[gi]  = req[w_cand[gi]];
   end

   always_comb begin
      gnt_idx = ptr;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (w_hit[k]) gnt_idx = w_cand[k];
      end
   end

   assign any = |req;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_gnt
      assign gnt[gi] = any && (gnt_idx == ch_idx_t'(gi));
   end

endmodule

// File: rtl/mux4_rr.sv
// Four-input round-robin mux onto one registered valid/ready output tagged with
// the source channel. Define MUX4_CNT_EN to add per-channel accepted-beat counters.
module mux4_rr
   import mux4_rr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   input  logic                    out_ready
`ifdef MUX4_CNT_EN
   ,
   output logic [NUM_CH*CNT_W-1:0] xfer_cnt
`endif
);

   state_t            r_state;
   state_t            w_state_next;
   ch_idx_t           r_ptr;
   ch_idx_t           r_sel;
   logic [WIDTH-1:0]  r_data;

   logic [NUM_CH-1:0] w_gnt;
   ch_idx_t           w_gnt_idx;
   logic              w_any;
   logic              w_load;
   logic [WIDTH-1:0]  w_data_mux;

   rr_arbiter4 u_arb (
      .req     (in_valid),
      .ptr     (r_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx),
      .any     (w_any)
   );

   // rst gates load so no producer sees a handshake while the mux is in reset
   assign w_load = !rst && ((r_state == ST_EMPTY) || out_ready) && w_any;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign in_ready[gi] = w_load && w_gnt[gi];
   end

   always_comb begin
      w_data_mux = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_gnt_idx == ch_idx_t'(k)) w_data_mux = in_data[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_load)         w_state_next = ST_FULL;
      else if (out_ready) w_state_next = ST_EMPTY;
   end

   // Data and tag are retained while empty; only a load overwrites them
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_sel  <= '0;
         r_ptr  <= '0;
      end else if (w_load) begin
         r_data <= w_data_mux;
         r_sel  <= w_gnt_idx;
         r_ptr  <= w_gnt_idx + ch_idx_t'(1);
      end
   end

   assign out_valid = (r_state == ST_FULL);
   assign out_data  = r_data;
   assign out_sel   = r_sel;

`ifdef MUX4_CNT_EN
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
         if (rst)                               r_cnt <= '0;
         else if (in_valid[gi] && in_ready[gi]) r_cnt <= r_cnt + 1'b1;
      end

      assign xfer_cnt[gi*CNT_W +: CNT_W] = r_cnt;
   end
`endif

endmodule

// File: tb/tb_mux4_rr.sv
// Self-checking bench for mux4_rr: directed scenarios plus randomized traffic
// compared against a round-robin reference model kept in the bench.
module tb_mux4_rr;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     in_valid;
   logic [4*W-1:0] in_data;
   logic [3:0]     in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_sel;
   logic           out_ready;
`ifdef MUX4_CNT_EN
   logic [31:0]    xfer_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int n_txn    = 0;

   // Reference model state
   bit         m_valid = 0;
   int         m_data  = 0;
   int         m_sel   = 0;
   int         m_ptr   = 0;
   int         m_cnt [4] = '{0, 0, 0, 0};
   logic [3:0] last_rdy = 4'h0;

   always #5 clk = ~clk;

   mux4_rr #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
`ifdef MUX4_CNT_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   // Called just after a falling edge: drive, check, cross one rising edge, update model.
   task automatic step(input logic [3:0] v, input logic [4*W-1:0] d, input logic ordy);
      int         win;
      bit         load;
      logic [3:0] exp_rdy;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      #1;
      win     = rr_pick(v, m_ptr);
      load    = !rst && (!m_valid || ordy) && (win >= 0);
      exp_rdy = load ? 4'(1 << win) : 4'b0;
      check_eq("in_ready",  32'(in_ready),  32'(exp_rdy));
      check_eq("out_valid", 32'(out_valid), 32'(m_valid));
      check_eq("out_data",  32'(out_data),  m_data);
      check_eq("out_sel",   32'(out_sel),   m_sel);
`ifdef MUX4_CNT_EN
      for (int i = 0; i < 4; i++) check_eq("xfer_cnt", 32'(xfer_cnt[i*8 +: 8]), m_cnt[i]);
`endif
      last_rdy = in_ready;
      $display("txn %0d rst=%0b v=%b ordy=%0b rdy=%b out_v=%0b sel=%0d data=%02h",
               n_txn, rst, v, ordy, in_ready, out_valid, out_sel, out_data);
      n_txn++;
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (load) begin
         m_valid      = 1;
         m_data       = int'(d[win*W +: W]);
         m_sel        = win;
         m_ptr        = (win + 1) % 4;
         m_cnt[win]   = (m_cnt[win] + 1) % 256;
      end else if (ordy) begin
         m_valid = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(4'h0, '0, 1'b1);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0]     rv;
      logic [4*W-1:0] rd;
      int             pulses [4];

      rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // Reset held two cycles, with traffic offered during the second
      step(4'h0, '0, 1'b1);
      step(4'hF, 32'h12345678, 1'b1);
      rst = 1'b0;
      step(4'h0, '0, 1'b1);
      check_eq("idle_valid", 32'(out_valid), 32'd0);
      check_eq("idle_sel",   32'(out_sel),   32'd0);

      // Single channel 2
      step(4'b0100, 32'h00A5_0000, 1'b1);
      check_eq("single_rdy", 32'(last_rdy), 32'b0100);
      step(4'h0, '0, 1'b0);
      check_eq("single_data", 32'(out_data), 32'hA5);
      check_eq("single_sel",  32'(out_sel),  32'd2);

      // Fairness: all four requesting for 8 cycles after a fresh reset
      do_reset();
      for (int i = 0; i < 4; i++) pulses[i] = 0;
      for (int k = 0; k < 8; k++) begin
         step(4'hF, 32'($urandom), 1'b1);
         for (int i = 0; i < 4; i++) pulses[i] += int'(last_rdy[i]);
         check_eq("rr_seq", 32'(out_sel), k % 4);
      end
      for (int i = 0; i < 4; i++) check_eq("rr_pulses", pulses[i], 32'd2);

      // Backpressure while ch3 waits, then wrap of the pointer back to ch0
      do_reset();
      step(4'b0010, 32'h0000_3C00, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(4'b1000, 32'hC300_0000, 1'b0);
         check_eq("bp_sel",  32'(out_sel),  32'd1);
         check_eq("bp_data", 32'(out_data), 32'h3C);
      end
      step(4'b1000, 32'hC300_0000, 1'b1);
      check_eq("bp_accept", 32'(last_rdy), 32'b1000);
      step(4'b1001, 32'hC300_0011, 1'b1);
      check_eq("bp_sel3",   32'(m_sel == 0 ? out_sel : out_sel), 32'd0);
      check_eq("wrap_rdy",  32'(last_rdy), 32'b0001);
      step(4'b1000, 32'hC300_0000, 1'b1);
      check_eq("wrap_rdy2", 32'(last_rdy), 32'b1000);

`ifdef MUX4_CNT_EN
      // 256 beats on ch1 wrap its counter; a mid-stream reset clears everything
      do_reset();
      for (int k = 0; k < 256; k++) step(4'b0010, 32'($urandom), 1'b1);
      step(4'h0, '0, 1'b1);
      check_eq("cnt_wrap", 32'(xfer_cnt[15:8]), 32'd0);
      for (int k = 0; k < 5; k++) step(4'b0110, 32'($urandom), 1'b1);
      rst = 1'b1;
      step(4'b0110, 32'($urandom), 1'b1);
      rst = 1'b0;
      step(4'h0, '0, 1'b0);
      check_eq("rst_cnt",   xfer_cnt, 32'd0);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
`endif

      // Randomized traffic; producers keep valid/data stable until accepted
      rv = '0; rd = '0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!(rv[i] && !last_rdy[i])) begin
               rv[i]       = ($urandom_range(0, 2) != 0);
               rd[i*W +: W] = W'($urandom);
            end
         end
         rst = ($urandom_range(0, 99) == 0);
         step(rv, rd, $urandom_range(0, 3) != 0);
         if (rst) rv = '0;
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
